uart_rx_edge_bit_counter: RTL and testbench
===========================================

// Module: uart_rx_edge_bit_counter
// PURPOSE
//  Parametrised oversampling edge/bit counter for the UART receiver path; successor to the fixed 1-bit counter.
//  Counts oversample edges per bit and bits per frame, with runtime prescale, optional parity and 1/2 stop bits.
//  Emits mid-bit sample strobes and bit/frame boundary pulses for the RX FSM, sampler and deserializer.
// PARAMETERS
//  PRESCALE_MAX  32  largest supported oversample ratio; power of 2, >=8
//  DATA_WIDTH    8   data bits per frame, 5..9
//  EDGE_W        $clog2(PRESCALE_MAX)  edge counter width (derived, localparam)
//  BIT_W         $clog2(DATA_WIDTH+4)  bit counter width (derived, localparam)
// PORTS
//  CLK         in   1       system clock, all logic on rising edge
//  RST         in   1       asynchronous, active-low reset
//  enable      in   1       frame active; driven by RX FSM from start detect until frame end
//  prescale    in   EDGE_W+1  oversample ratio: 8, 16 or 32 (must be <= PRESCALE_MAX)
//  par_en      in   1       1 = parity bit present after data
//  stop2       in   1       1 = two stop bits, 0 = one
//  edge_cnt    out  EDGE_W  current edge index within bit, 0..prescale-1
//  bit_cnt     out  BIT_W   current bit index: 0 = start, 1..DATA_WIDTH = data, then parity, then stop(s)
//  sample_stb  out  1       high on edges prescale/2-1, prescale/2, prescale/2+1 (3-sample majority window)
//  bit_done    out  1       pulse on last edge of every bit (edge_cnt == prescale-1)
//  frame_done  out  1       pulse on last edge of last stop bit
//  phase       out  3       START/DATA/PARITY/STOP/IDLE encoding of the bit being counted
// BEHAVIOUR
//  - Reset (RST=0): edge_cnt=0, bit_cnt=0, all pulses 0, phase=IDLE, latched config cleared to prescale=8,
//    par_en=0, stop2=0.
//  - All counters registered; strobes/pulses are registered decodes aligned with the edge_cnt value they mark
//    (decode of next-state, no extra cycle of latency).
//  - Config latch: prescale/par_en/stop2 captured on the cycle enable rises (enable=1 while in IDLE);
//    changes mid-frame ignored until next frame.
//  - Frame length L = 1 + DATA_WIDTH + par_en + 1 + stop2 bits.
//  - FSM states: IDLE, COUNT. IDLE->COUNT when enable=1. COUNT->IDLE when frame_done fires or enable=0.
//  - COUNT: edge_cnt increments each cycle; at prescale-1 wraps to 0 and bit_cnt increments.
//    At bit_cnt==L-1 and edge_cnt==prescale-1, frame_done=1 and bit_done=1 in the same cycle;
//    next cycle counters=0, phase=IDLE.
//  - enable=0 at any time (mid-frame abort, e.g. false start): counters cleared on the next edge, no pulses,
//    phase=IDLE.
//  - enable held high after frame_done: block returns to IDLE for exactly one cycle, then restarts at bit 0
//    with re-latched config (back-to-back frames).
//  - Unsupported prescale value (not 8/16/32): treated as 16.
//  - phase: bit 0 -> START; 1..DATA_WIDTH -> DATA; parity bit -> PARITY (only if par_en); remaining -> STOP.
//  - Async reset mid-frame: immediate return to reset values; no frame_done emitted.
// STRUCTURE
//  - Shared package uart_pkg: phase encoding localparams (PH_IDLE, PH_START, PH_DATA, PH_PARITY, PH_STOP),
//    supported prescale constants, default prescale.
//  - Single module; no sub-module required. Edge counter, bit counter and strobe decode in one file.
// TESTING
//  1. prescale=8, par_en=0, stop2=0, enable held 80 cycles -> bit_cnt 0..9, frame_done once at cycle 79,
//     sample_stb on edges 3,4,5 of each bit.
//  2. prescale=16, par_en=1, stop2=1 -> L=12, frame_done at cycle 191; phase=PARITY for bit 9, STOP for 10-11.
//  3. prescale=32, enable dropped at bit 4 edge 10 -> next cycle edge_cnt=0, bit_cnt=0, phase=IDLE,
//     no frame_done.
//  4. Change prescale 8->16 mid-frame -> current frame continues at 8; next frame counts 16 edges/bit.
//  5. enable held across two frames (prescale=8, L=10) -> frame_done at 79, one IDLE cycle,
//     second frame_done at 160.
//  6. RST low at bit 6 -> all outputs 0 immediately; prescale=5 after reset -> behaves as 16.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: counter FSM states, phase encoding and prescale constants.
package uart_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } cnt_state_t;

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_START  = 3'd1;
    localparam logic [2:0] PH_DATA   = 3'd2;
    localparam logic [2:0] PH_PARITY = 3'd3;
    localparam logic [2:0] PH_STOP   = 3'd4;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // Substituted for any unsupported ratio; reset value is the smallest ratio.
    localparam int unsigned PRESCALE_DEFAULT = PRESCALE_16;
    localparam int unsigned PRESCALE_RESET   = PRESCALE_8;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge / frame bit counter for the UART RX path.
// Emits mid-bit sample strobes and bit/frame boundary pulses aligned with the counter values.
module uart_rx_edge_bit_counter
    import uart_pkg::*;
#(
    parameter  int unsigned PRESCALE_MAX = 32,
    parameter  int unsigned DATA_WIDTH   = 8,
    localparam int unsigned EDGE_W       = $clog2(PRESCALE_MAX),
    localparam int unsigned BIT_W        = $clog2(DATA_WIDTH + 4)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic [EDGE_W:0]   prescale,
    input  logic              par_en,
    input  logic              stop2,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              sample_stb,
    output logic              bit_done,
    output logic              frame_done,
    output logic [2:0]        phase
);

    localparam int unsigned PS_W = EDGE_W + 1;

    cnt_state_t        state, state_nxt;
    logic [PS_W-1:0]   cfg_ps, cfg_ps_nxt;
    logic              cfg_par, cfg_par_nxt;
    logic              cfg_stop2, cfg_stop2_nxt;
    logic [EDGE_W-1:0] edge_nxt;
    logic [BIT_W-1:0]  bit_nxt;
    logic              sample_nxt, bit_done_nxt, frame_done_nxt;
    logic [2:0]        phase_nxt;
    logic [EDGE_W-1:0] last_edge_c, nxt_last_edge_c, nxt_half_c;
    logic [BIT_W-1:0]  last_bit_c, nxt_last_bit_c;
    logic              active_c;

    // Map a requested ratio onto a supported one; anything else counts as 16.
    function automatic logic [PS_W-1:0] fix_prescale(input logic [PS_W-1:0] p);
        int unsigned pv;
        pv = 32'(p);
        if ((pv == PRESCALE_8 || pv == PRESCALE_16 || pv == PRESCALE_32) && pv <= PRESCALE_MAX)
            return PS_W'(pv);
        return PS_W'(PRESCALE_DEFAULT);
    endfunction

    // Next-state counters, then decode of the pulses from the next-state values.
    always_comb begin
        cfg_ps_nxt     = cfg_ps;
        cfg_par_nxt    = cfg_par;
        cfg_stop2_nxt  = cfg_stop2;
        state_nxt      = ST_IDLE;
        edge_nxt       = '0;
        bit_nxt        = '0;
        last_edge_c    = EDGE_W'(cfg_ps - PS_W'(1));
        last_bit_c     = BIT_W'(DATA_WIDTH + 1) + BIT_W'(cfg_par) + BIT_W'(cfg_stop2);

        if (state == ST_IDLE) begin
            if (enable) begin
                cfg_ps_nxt    = fix_prescale(prescale);
                cfg_par_nxt   = par_en;
                cfg_stop2_nxt = stop2;
                state_nxt     = ST_COUNT;
            end
        end else if (enable) begin
            state_nxt = ST_COUNT;
            if (edge_cnt != last_edge_c) begin
                edge_nxt = edge_cnt + EDGE_W'(1);
                bit_nxt  = bit_cnt;
            end else if (bit_cnt != last_bit_c) begin
                bit_nxt = bit_cnt + BIT_W'(1);
            end else begin
                state_nxt = ST_IDLE;
            end
        end

        active_c        = (state_nxt == ST_COUNT);
        nxt_last_edge_c = EDGE_W'(cfg_ps_nxt - PS_W'(1));
        nxt_half_c      = EDGE_W'(cfg_ps_nxt >> 1);
        nxt_last_bit_c  = BIT_W'(DATA_WIDTH + 1) + BIT_W'(cfg_par_nxt) + BIT_W'(cfg_stop2_nxt);

        sample_nxt     = active_c && ((edge_nxt + EDGE_W'(1) == nxt_half_c) ||
                                      (edge_nxt == nxt_half_c) ||
                                      (edge_nxt == nxt_half_c + EDGE_W'(1)));
        bit_done_nxt   = active_c && (edge_nxt == nxt_last_edge_c);
        frame_done_nxt = bit_done_nxt && (bit_nxt == nxt_last_bit_c);

        if (!active_c)
            phase_nxt = PH_IDLE;
        else if (bit_nxt == '0)
            phase_nxt = PH_START;
        else if (bit_nxt <= BIT_W'(DATA_WIDTH))
            phase_nxt = PH_DATA;
        else if (cfg_par_nxt && bit_nxt == BIT_W'(DATA_WIDTH + 1))
            phase_nxt = PH_PARITY;
        else
            phase_nxt = PH_STOP;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            cfg_ps     <= PS_W'(PRESCALE_RESET);
            cfg_par    <= 1'b0;
            cfg_stop2  <= 1'b0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            sample_stb <= 1'b0;
            bit_done   <= 1'b0;
            frame_done <= 1'b0;
            phase      <= PH_IDLE;
        end else begin
            state      <= state_nxt;
            cfg_ps     <= cfg_ps_nxt;
            cfg_par    <= cfg_par_nxt;
            cfg_stop2  <= cfg_stop2_nxt;
            edge_cnt   <= edge_nxt;
            bit_cnt    <= bit_nxt;
            sample_stb <= sample_nxt;
            bit_done   <= bit_done_nxt;
            frame_done <= frame_done_nxt;
            phase      <= phase_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_edge_bit_counter.sv
// Bench for uart_rx_edge_bit_counter: directed frame scenarios plus random traffic
// compared each cycle against a flat frame-position reference model.
module tb_uart_rx_edge_bit_counter;
    import uart_pkg::*;

    localparam int unsigned DW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [5:0] prescale;
    logic       par_en;
    logic       stop2;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sample_stb, bit_done, frame_done;
    logic [2:0] phase;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned fd_q[$];

    // Reference model: frame position as a single flat cycle index.
    bit          m_act = 0;
    bit          m_par = 0;
    int unsigned m_k = 0, m_p = 8, m_len = 10;

    uart_rx_edge_bit_counter #(.PRESCALE_MAX(32), .DATA_WIDTH(DW)) dut (
        .CLK(clk), .RST(rst_n), .enable(enable), .prescale(prescale),
        .par_en(par_en), .stop2(stop2), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .sample_stb(sample_stb), .bit_done(bit_done), .frame_done(frame_done), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned eff_ps(input int unsigned v);
        return (v == 8 || v == 16 || v == 32) ? v : 16;
    endfunction

    function automatic void model_clock(input bit en, input int unsigned ps, input bit pe, input bit s2);
        if (!m_act) begin
            if (en) begin
                m_act = 1; m_k = 0; m_p = eff_ps(ps); m_par = pe;
                m_len = DW + 2 + int'(pe) + int'(s2);
            end
        end else if (!en || m_k == m_p * m_len - 1) begin
            m_act = 0;
        end else begin
            m_k++;
        end
    endfunction

    task automatic check_outputs();
        int unsigned e, b, ph;
        e = m_act ? m_k % m_p : 0;
        b = m_act ? m_k / m_p : 0;
        if (!m_act)                  ph = 32'(PH_IDLE);
        else if (b == 0)             ph = 32'(PH_START);
        else if (b <= DW)            ph = 32'(PH_DATA);
        else if (m_par && b == DW+1) ph = 32'(PH_PARITY);
        else                         ph = 32'(PH_STOP);
        check("edge_cnt", 32'(edge_cnt), e);
        check("bit_cnt", 32'(bit_cnt), b);
        check("phase", 32'(phase), ph);
        check("sample_stb", 32'(sample_stb), 32'(m_act && e + 1 >= m_p / 2 && e <= m_p / 2 + 1));
        check("bit_done", 32'(bit_done), 32'(m_act && e == m_p - 1));
        check("frame_done", 32'(frame_done), 32'(m_act && m_k == m_p * m_len - 1));
    endtask

    // One clock: drive at negedge, model the posedge, check at the following negedge.
    task automatic step(input bit en, input logic [5:0] ps, input bit pe, input bit s2);
        enable = en; prescale = ps; par_en = pe; stop2 = s2;
        @(posedge clk);
        model_clock(en, 32'(ps), pe, s2);
        @(negedge clk);
        cyc++;
        if (frame_done) fd_q.push_back(cyc);
        check_outputs();
    endtask

    task automatic run(input int unsigned n, input bit en, input logic [5:0] ps, input bit pe, input bit s2);
        for (int i = 0; i < int'(n); i++) step(en, ps, pe, s2);
    endtask

    initial begin
        int unsigned t0;
        logic [5:0]  r_ps;
        bit          r_pe, r_s2;

        rst_n = 1'b0; enable = 1'b0; prescale = 6'd8; par_en = 1'b0; stop2 = 1'b0;
        @(negedge clk); @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        run(2, 0, 6'd8, 0, 0);

        // prescale 8, no parity, one stop: 80 cycles
        fd_q.delete(); t0 = cyc + 1;
        run(80, 1, 6'd8, 0, 0);
        run(2, 0, 6'd8, 0, 0);
        check("t1_fd_count", fd_q.size(), 1);
        if (fd_q.size() > 0) check("t1_fd_cycle", fd_q[0] - t0, 79);

        // prescale 16, parity, two stop bits: L = 12
        fd_q.delete(); t0 = cyc + 1;
        run(192, 1, 6'd16, 1, 1);
        run(2, 0, 6'd16, 0, 0);
        check("t2_fd_count", fd_q.size(), 1);
        if (fd_q.size() > 0) check("t2_fd_cycle", fd_q[0] - t0, 191);

        // prescale 32, abort at bit 4 edge 10
        fd_q.delete();
        run(4 * 32 + 11, 1, 6'd32, 0, 0);
        check("t3_pre_edge", 32'(edge_cnt), 10);
        check("t3_pre_bit", 32'(bit_cnt), 4);
        run(1, 0, 6'd32, 0, 0);
        check("t3_edge", 32'(edge_cnt), 0);
        check("t3_phase", 32'(phase), 32'(PH_IDLE));
        run(2, 0, 6'd32, 0, 0);
        check("t3_no_fd", fd_q.size(), 0);

        // prescale changed 8 -> 16 mid-frame; next frame uses 16
        fd_q.delete(); t0 = cyc + 1;
        run(20, 1, 6'd8, 0, 0);
        run(61 + 160, 1, 6'd16, 0, 0);
        run(2, 0, 6'd16, 0, 0);
        check("t4_fd_count", fd_q.size(), 2);
        if (fd_q.size() > 1) begin
            check("t4_fd0", fd_q[0] - t0, 79);
            check("t4_fd1", fd_q[1] - t0, 240);
        end

        // back-to-back frames at prescale 8
        fd_q.delete(); t0 = cyc + 1;
        run(161, 1, 6'd8, 0, 0);
        run(3, 0, 6'd8, 0, 0);
        check("t5_fd_count", fd_q.size(), 2);
        if (fd_q.size() > 1) begin
            check("t5_fd0", fd_q[0] - t0, 79);
            check("t5_fd1", fd_q[1] - t0, 160);
        end

        // async reset mid-frame, then unsupported prescale 5 behaves as 16
        fd_q.delete();
        run(6 * 8 + 3, 1, 6'd8, 0, 0);
        #2 rst_n = 1'b0; enable = 1'b0;
        #1;
        m_act = 0;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_no_fd", fd_q.size(), 0);
        t0 = cyc + 1;
        run(160, 1, 6'd5, 0, 0);
        run(2, 0, 6'd5, 0, 0);
        check("t6_fd_count", fd_q.size(), 1);
        if (fd_q.size() > 0) check("t6_fd_cycle", fd_q[0] - t0, 159);

        // random traffic: occasional aborts and config changes at any time
        r_ps = 6'd8; r_pe = 0; r_s2 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r_ps = 6'd8;
                    1:       r_ps = 6'd16;
                    2:       r_ps = 6'd32;
                    default: r_ps = 6'($urandom_range(0, 63));
                endcase
                r_pe = 1'($urandom_range(0, 1));
                r_s2 = 1'($urandom_range(0, 1));
            end
            step($urandom_range(0, 99) < 97, r_ps, r_pe, r_s2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
